// File: rtl/vx_cache_perf_agg.sv
// vx_cache_perf_agg: per-cache performance event aggregator.
// Popcounts per-bank event strobes, accumulates them into per-event counters
// with optional saturation and sticky overflow flags, and exposes
// read-and-clear snapshots through a valid/ready handshake.
module vx_cache_perf_agg #(
  parameter int NUM_BANKS  = 4,
  parameter int NUM_EVENTS = 8,
  parameter int CTR_BITS   = 44,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_BANKS*NUM_EVENTS-1:0] bank_events,
  input  logic                           clear,
  input  logic                           snap_req,
  output logic                           snap_valid,
  input  logic                           snap_ready,
  output logic [NUM_EVENTS*CTR_BITS-1:0] snap_data,
  output logic [NUM_EVENTS*CTR_BITS-1:0] counters,
  output logic [NUM_EVENTS-1:0]          overflow
);

  localparam int IW = $clog2(NUM_BANKS + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [IW-1:0]                  inc_d [NUM_EVENTS];
  logic [IW-1:0]                  inc_q [NUM_EVENTS];
  logic [CTR_BITS:0]              sum   [NUM_EVENTS];
  logic [CTR_BITS-1:0]            ctr_d [NUM_EVENTS];
  logic [CTR_BITS-1:0]            ctr_q [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]          ovf_d;
  logic [NUM_EVENTS-1:0]          ovf_q;
  logic [NUM_EVENTS*CTR_BITS-1:0] ctr_d_flat;
  logic [NUM_EVENTS*CTR_BITS-1:0] ctr_q_flat;
  logic [NUM_EVENTS*CTR_BITS-1:0] snap_q;
  logic                           valid_q;
  state_t                         state_q;

  // Popcount of each event's strobes across all banks.
  always_comb begin
    for (int e = 0; e < NUM_EVENTS; e++) begin
      inc_d[e] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        inc_d[e] = inc_d[e] + IW'(bank_events[b*NUM_EVENTS+e]);
      end
    end
  end

  // Stage 1: register per-event increments; disabled or clearing cycles contribute nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_EVENTS; e++) inc_q[e] <= '0;
    end else begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        inc_q[e] <= (clear || !enable) ? '0 : inc_d[e];
      end
    end
  end

  // Next counter value before the clear mux; the extra sum bit is the overflow carry.
  always_comb begin
    for (int e = 0; e < NUM_EVENTS; e++) begin
      sum[e] = {1'b0, ctr_q[e]} + {{(CTR_BITS + 1 - IW){1'b0}}, inc_q[e]};
      if (sum[e][CTR_BITS]) begin
        ctr_d[e] = (SATURATE != 0) ? {CTR_BITS{1'b1}} : sum[e][CTR_BITS-1:0];
        ovf_d[e] = 1'b1;
      end else begin
        ctr_d[e] = sum[e][CTR_BITS-1:0];
        ovf_d[e] = ovf_q[e];
      end
    end
  end

  // Flatten next and live counters into the packed output layout.
  always_comb begin
    ctr_d_flat = '0;
    ctr_q_flat = '0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      ctr_d_flat[e*CTR_BITS +: CTR_BITS] = ctr_d[e];
      ctr_q_flat[e*CTR_BITS +: CTR_BITS] = ctr_q[e];
    end
  end

  // Stage 2: accumulate; clear wins over the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_EVENTS; e++) ctr_q[e] <= '0;
      ovf_q <= '0;
    end else if (clear) begin
      for (int e = 0; e < NUM_EVENTS; e++) ctr_q[e] <= '0;
      ovf_q <= '0;
    end else begin
      for (int e = 0; e < NUM_EVENTS; e++) ctr_q[e] <= ctr_d[e];
      ovf_q <= ovf_d;
    end
  end

  // Snapshot FSM: capture pre-clear next value on request, hold until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (snap_req) begin
            snap_q  <= ctr_d_flat;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (snap_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign snap_valid = valid_q;
  assign snap_data  = snap_q;
  assign counters   = ctr_q_flat;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vx_cache_perf_agg.sv
// Directed bench for vx_cache_perf_agg: a default 44-bit instance plus two
// 8-bit instances (saturating and wrapping) sharing one stimulus stream.
module tb_vx_cache_perf_agg;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] bank_events;
  logic        clear;
  logic        snap_req;
  logic        snap_ready;

  logic         sv_d, sv_s, sv_w;
  logic [351:0] sd_d, ct_d;
  logic [63:0]  sd_s, ct_s, sd_w, ct_w;
  logic [7:0]   ov_d, ov_s, ov_w;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] RD4 = 32'h0101_0101;
  localparam logic [31:0] RD2 = 32'h0000_0101;
  localparam logic [31:0] WR4 = 32'h0202_0202;
  localparam logic [31:0] WR3 = 32'h0002_0202;

  vx_cache_perf_agg #(.NUM_BANKS(4), .NUM_EVENTS(8), .CTR_BITS(44), .SATURATE(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .bank_events(bank_events),
    .clear(clear), .snap_req(snap_req), .snap_valid(sv_d), .snap_ready(snap_ready),
    .snap_data(sd_d), .counters(ct_d), .overflow(ov_d));

  vx_cache_perf_agg #(.NUM_BANKS(4), .NUM_EVENTS(8), .CTR_BITS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .bank_events(bank_events),
    .clear(clear), .snap_req(snap_req), .snap_valid(sv_s), .snap_ready(snap_ready),
    .snap_data(sd_s), .counters(ct_s), .overflow(ov_s));

  vx_cache_perf_agg #(.NUM_BANKS(4), .NUM_EVENTS(8), .CTR_BITS(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .bank_events(bank_events),
    .clear(clear), .snap_req(snap_req), .snap_valid(sv_w), .snap_ready(snap_ready),
    .snap_data(sd_w), .counters(ct_w), .overflow(ov_w));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; bank_events = '0; clear = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(sv_d), 64'd0);
    chk("rst_ctr_any", 64'(|ct_d), 64'd0);
    chk("rst_snap_any", 64'(|sd_d), 64'd0);
    chk("rst_ovf", 64'(ov_d), 64'd0);
    #2 reset = 1'b0;

    // Test 1: three cycles of four read strobes -> 12.
    enable = 1'b1;
    bank_events = RD4; tick(); tick(); tick();
    bank_events = '0;
    chk("t1_reads_mid", ct_d[0 +: 44], 64'd8);
    tick();
    chk("t1_reads", ct_d[0 +: 44], 64'd12);
    chk("t1_writes", ct_d[44 +: 44], 64'd0);
    chk("t1_stalls", ct_d[308 +: 44], 64'd0);
    tick();
    chk("t1_reads_hold", ct_d[0 +: 44], 64'd12);

    // Test 3: snapshot holds while counters keep running.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3_cleared", ct_d[0 +: 44], 64'd0);
    bank_events = RD4; tick();
    bank_events = RD4; tick();
    bank_events = RD2; tick();
    bank_events = RD4; tick();
    chk("t3_reads10", ct_d[0 +: 44], 64'd10);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("t3_snap", sd_d[0 +: 44], 64'd14);
    chk("t3_valid", 64'(sv_d), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_snap_stable", sd_d[0 +: 44], 64'd14);
      chk("t3_valid_hold", 64'(sv_d), 64'd1);
    end
    chk("t3_reads_grow", ct_d[0 +: 44], 64'd34);
    bank_events = '0;
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    chk("t3_valid_drop", 64'(sv_d), 64'd0);
    chk("t3_snap_kept", sd_d[0 +: 44], 64'd14);

    // Test 4: read-and-clear with writes=7.
    clear = 1'b1; tick(); clear = 1'b0;
    bank_events = WR4; tick();
    bank_events = WR3; tick();
    bank_events = '0; tick(); tick();
    chk("t4_writes7", ct_d[44 +: 44], 64'd7);
    snap_req = 1'b1; clear = 1'b1; bank_events = '1; tick();
    snap_req = 1'b0; clear = 1'b0; bank_events = '0;
    chk("t4_snap_writes", sd_d[44 +: 44], 64'd7);
    chk("t4_snap_reads", sd_d[0 +: 44], 64'd0);
    chk("t4_ctr_zero", 64'(|ct_d), 64'd0);
    chk("t4_ovf_zero", 64'(ov_d), 64'd0);
    chk("t4_valid", 64'(sv_d), 64'd1);
    tick();
    chk("t4_dropped", 64'(|ct_d), 64'd0);
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    chk("t4_idle", 64'(sv_d), 64'd0);

    // Test 2/2b: 8-bit saturating vs wrapping at the top of range.
    clear = 1'b1; tick(); clear = 1'b0;
    bank_events = RD4;
    for (int i = 0; i < 63; i++) tick();
    bank_events = '0; tick();
    chk("t2_sat_252", ct_s[0 +: 8], 64'd252);
    chk("t2_wrap_252", ct_w[0 +: 8], 64'd252);
    chk("t2_wide_252", ct_d[0 +: 44], 64'd252);
    chk("t2_sat_ovf0", 64'(ov_s), 64'd0);
    bank_events = RD4; tick(); bank_events = '0; tick();
    chk("t2_sat_255", ct_s[0 +: 8], 64'd255);
    chk("t2_sat_ovf", 64'(ov_s), 64'd1);
    chk("t2b_wrap_0", ct_w[0 +: 8], 64'd0);
    chk("t2b_wrap_ovf", 64'(ov_w), 64'd1);
    chk("t2_wide_256", ct_d[0 +: 44], 64'd256);
    chk("t2_wide_ovf0", 64'(ov_d), 64'd0);
    bank_events = RD4; tick(); bank_events = '0; tick();
    chk("t2_sat_stay", ct_s[0 +: 8], 64'd255);
    chk("t2_sat_ovf_stay", 64'(ov_s), 64'd1);
    chk("t2b_wrap_4", ct_w[0 +: 8], 64'd4);
    chk("t2b_wrap_ovf_stay", 64'(ov_w), 64'd1);

    // Test 5: enable low drops everything; reset kills a held snapshot.
    enable = 1'b0; bank_events = '1;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_reads_frozen", ct_d[0 +: 44], 64'd260);
    chk("t5_writes_frozen", ct_d[44 +: 44], 64'd0);
    chk("t5_wrap_frozen", ct_w[0 +: 8], 64'd4);
    bank_events = '0; enable = 1'b1;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("t5_hold", 64'(sv_d), 64'd1);
    chk("t5_snap", sd_d[0 +: 44], 64'd260);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(sv_d), 64'd0);
    chk("t5_rst_ctr", 64'(|ct_d), 64'd0);
    chk("t5_rst_snap", 64'(|sd_d), 64'd0);
    chk("t5_rst_sat_ovf", 64'(ov_s), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
